// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the iterative RV64M multiplier.
package mul_pkg;

    localparam logic [2:0] MUL_F3    = 3'b000;
    localparam logic [2:0] MULH_F3   = 3'b001;
    localparam logic [2:0] MULHSU_F3 = 3'b010;
    localparam logic [2:0] MULHU_F3  = 3'b011;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_R32 = 7'b0111011;
    localparam logic [6:0] MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_step.sv
// Combinational radix-2^STEP_W partial-product step: acc + mcand * bits.
module mul_step #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STEP_W = 2
) (
    input  logic [2*DATA_W-1:0] i_acc,
    input  logic [2*DATA_W-1:0] i_mcand,
    input  logic [STEP_W-1:0]   i_bits,
    output logic [2*DATA_W-1:0] o_acc
);

    always_comb begin
        o_acc = i_acc;
        for (int i = 0; i < STEP_W; i++) begin
            if (i_bits[i]) begin
                o_acc = o_acc + (i_mcand << i);
            end
        end
    end

endmodule

// File: rtl/iter_mul_unit.sv
// Multi-cycle RV64M multiplier (MUL/MULH/MULHSU/MULHU/MULW) for the EX stage.
module iter_mul_unit
    import mul_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned STEP_W = 2
) (
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic              i_enable,
    input  logic              i_start,
    input  logic              i_flush,
    input  logic [2:0]        i_func3,
    input  logic              i_is_word,
    input  logic [DATA_W-1:0] i_op_a,
    input  logic [DATA_W-1:0] i_op_b,
    output logic              o_stall,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_result
);

    localparam int unsigned N_FULL = DATA_W / STEP_W;
    localparam int unsigned N_WORD = 32 / STEP_W;
    localparam int unsigned CNT_W  = $clog2(N_FULL);
    localparam int unsigned P_W    = 2 * DATA_W;
    localparam logic [DATA_W-1:0] LO_MASK = DATA_W'({32{1'b1}});

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [P_W-1:0]      r_acc;
    logic [P_W-1:0]      r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic                r_neg;
    logic [2:0]          r_func3;
    logic                r_word;
    logic [DATA_W-1:0]   r_result;

    logic                w_legal;
    logic                w_accept;
    logic                w_neg_a;
    logic                w_neg_b;
    logic [DATA_W-1:0]   w_ld_a;
    logic [DATA_W-1:0]   w_ld_b;
    logic [P_W-1:0]      w_acc_next;
    logic [P_W-1:0]      w_prod;
    logic [DATA_W-1:0]   w_res;

    assign w_legal  = !i_func3[2] && (!i_is_word || i_func3 == MUL_F3);
    assign w_accept = (r_state == IDLE) && i_start && w_legal && !i_flush && i_enable;

    assign w_neg_a = !i_is_word && (i_func3 == MULH_F3 || i_func3 == MULHSU_F3)
                     && i_op_a[DATA_W-1];
    assign w_neg_b = !i_is_word && (i_func3 == MULH_F3) && i_op_b[DATA_W-1];

    // Low 32 bits of a word product do not depend on operand signedness.
    assign w_ld_a = i_is_word ? (i_op_a & LO_MASK) : (w_neg_a ? -i_op_a : i_op_a);
    assign w_ld_b = i_is_word ? (i_op_b & LO_MASK) : (w_neg_b ? -i_op_b : i_op_b);

    mul_step #(
        .DATA_W (DATA_W),
        .STEP_W (STEP_W)
    ) u_step (
        .i_acc   (r_acc),
        .i_mcand (r_mcand),
        .i_bits  (r_mplier[STEP_W-1:0]),
        .o_acc   (w_acc_next)
    );

    assign w_prod = r_neg ? -w_acc_next : w_acc_next;

    always_comb begin
        w_res = w_prod[DATA_W-1:0];
        if (r_word) begin
            w_res = DATA_W'($signed(w_prod[31:0]));
        end else if (r_func3 != MUL_F3) begin
            w_res = w_prod[P_W-1:DATA_W];
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_func3  <= '0;
            r_word   <= 1'b0;
            r_result <= '0;
        end else if (i_enable) begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc    <= '0;
                        r_mcand  <= P_W'(w_ld_a);
                        r_mplier <= w_ld_b;
                        r_neg    <= w_neg_a ^ w_neg_b;
                        r_func3  <= i_func3;
                        r_word   <= i_is_word;
                        r_cnt    <= i_is_word ? CNT_W'(N_WORD - 1) : CNT_W'(N_FULL - 1);
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    if (i_flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mcand  <= r_mcand << STEP_W;
                        r_mplier <= r_mplier >> STEP_W;
                        r_cnt    <= r_cnt - CNT_W'(1);
                        if (r_cnt == '0) begin
                            r_result <= w_res;
                            r_state  <= DONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_stall  = w_accept || (r_state == CALC);
    assign o_busy   = (r_state == CALC);
    assign o_done   = (r_state == DONE);
    assign o_result = r_result;

endmodule

// File: tb/tb_iter_mul_unit.sv
// Directed self-checking bench for iter_mul_unit (DATA_W=64, STEP_W=2).
module tb_iter_mul_unit;

    logic        clk = 1'b0;
    logic        arst;
    logic        enable;
    logic        start;
    logic        flush;
    logic [2:0]  func3;
    logic        is_word;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    iter_mul_unit #(
        .DATA_W (64),
        .STEP_W (2)
    ) dut (
        .i_clk    (clk),
        .i_arst   (arst),
        .i_enable (enable),
        .i_start  (start),
        .i_flush  (flush),
        .i_func3  (func3),
        .i_is_word(is_word),
        .i_op_a   (op_a),
        .i_op_b   (op_b),
        .o_stall  (stall),
        .o_busy   (busy),
        .o_done   (done),
        .o_result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b);
        @(negedge clk);
        func3   = f3;
        is_word = w;
        op_a    = a;
        op_b    = b;
        start   = 1'b1;
        #1;
    endtask

    // Counts stall-high cycles from the accept cycle; hold keeps start asserted throughout.
    task automatic run_op(input vec_t v, input logic hold);
        int cnt;
        issue(v.f3, v.w, v.a, v.b);
        cnt = 0;
        while (stall === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
            if (!hold) start = 1'b0;
            #1;
        end
        chk({v.name, "_stall_cycles"}, 64'(cnt), 64'(v.lat));
        chk({v.name, "_done"}, {63'd0, done}, 64'd1);
        chk({v.name, "_dstall"}, {63'd0, stall}, 64'd0);
        chk({v.name, "_result"}, result, v.exp);
        start = 1'b0;
        @(negedge clk);
        #1;
        chk({v.name, "_done_clr"}, {63'd0, done}, 64'd0);
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) seen = 1'b1;
        end
        chk(name, {63'd0, seen}, 64'd0);
    endtask

    initial begin
        vecs[0] = '{"mul_7xm3",   3'b000, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD,
                    64'hFFFF_FFFF_FFFF_FFEB, 33};
        vecs[1] = '{"mulhu_ones", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[2] = '{"mulh_ones",  3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'h0, 33};
        vecs[3] = '{"mulhsu_m1x2", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
                    64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[4] = '{"mulh_minmin", 3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    64'h4000_0000_0000_0000, 33};
        vecs[5] = '{"mulw_max2",  3'b000, 1'b1, 64'h7FFF_FFFF, 64'h2,
                    64'hFFFF_FFFF_FFFF_FFFE, 17};
        vecs[6] = '{"mul_zero",   3'b000, 1'b0, 64'h0, 64'h1234, 64'h0, 33};
        vecs[7] = '{"mulhu_2p64", 3'b011, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'h1, 33};
        vecs[8] = '{"mulw_upper", 3'b000, 1'b1, 64'hDEAD_0000_0000_0003, 64'h1234_0000_FFFF_FFFF,
                    64'hFFFF_FFFF_FFFF_FFFD, 17};
        vecs[9] = '{"mulh_2p62x4", 3'b001, 1'b0, 64'h4000_0000_0000_0000, 64'h4, 64'h1, 33};

        arst    = 1'b1;
        enable  = 1'b1;
        start   = 1'b0;
        flush   = 1'b0;
        func3   = 3'b000;
        is_word = 1'b0;
        op_a    = '0;
        op_b    = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", {result[60:0], stall, busy, done}, 64'd0);
        arst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i], 1'b0);
        end

        // start held high through CALC and DONE must not re-trigger the operation.
        run_op(vecs[0], 1'b1);

        // Flush after 10 CALC cycles: back to IDLE, no done, result untouched.
        issue(3'b011, 1'b0, 64'h5, 64'h6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_stall", {63'd0, stall}, 64'd0);
        chk("flush_busy", {63'd0, busy}, 64'd0);
        watch_no_done("flush_no_done", 40);
        chk("flush_result_kept", result, 64'hFFFF_FFFF_FFFF_FFEB);

        // flush beats a simultaneous start in IDLE.
        @(negedge clk);
        func3 = 3'b000;
        start = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_vs_start_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_vs_start_busy", {63'd0, busy}, 64'd0);

        // Asynchronous reset in the middle of an operation.
        issue(3'b000, 1'b0, 64'h7, 64'h9);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        arst = 1'b1;
        #1;
        chk("arst_outputs", {result[60:0], stall, busy, done}, 64'd0);
        @(negedge clk);
        arst = 1'b0;
        watch_no_done("arst_no_done", 40);

        // Enable dropped for 4 CALC cycles, then frozen in DONE for 2 cycles.
        begin
            int cnt;
            logic busy_lost;
            busy_lost = 1'b0;
            issue(3'b000, 1'b0, 64'h7, 64'hFFFF_FFFF_FFFF_FFFD);
            cnt = 0;
            while (stall === 1'b1 && cnt < 200) begin
                cnt++;
                @(negedge clk);
                start  = 1'b0;
                enable = !(cnt >= 6 && cnt < 10);
                #1;
                if (!enable && busy !== 1'b1) busy_lost = 1'b1;
            end
            chk("en_stall_cycles", 64'(cnt), 64'd37);
            chk("en_busy_held", {63'd0, busy_lost}, 64'd0);
            chk("en_done", {63'd0, done}, 64'd1);
            chk("en_result", result, 64'hFFFF_FFFF_FFFF_FFEB);
            enable = 1'b0;
            @(negedge clk);
            #1;
            chk("en_done_frozen1", {63'd0, done}, 64'd1);
            @(negedge clk);
            #1;
            chk("en_done_frozen2", {63'd0, done}, 64'd1);
            enable = 1'b1;
            @(negedge clk);
            #1;
            chk("en_done_release", {63'd0, done}, 64'd0);
        end

        // Division func3 and MULH-with-is_word are not accepted.
        issue(3'b100, 1'b0, 64'h8, 64'h2);
        chk("div_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("div_busy", {63'd0, busy}, 64'd0);
        issue(3'b001, 1'b1, 64'h8, 64'h2);
        chk("mulhw_stall", {63'd0, stall}, 64'd0);
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("mulhw_busy", {63'd0, busy}, 64'd0);
        chk("illegal_result_kept", result, 64'hFFFF_FFFF_FFFF_FFEB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iter_mul_unit.md
Name: iter_mul_unit

Overview:
- Multi-cycle RV64M integer multiplier in the EX stage, beside the ALU.
- Consumes ID/EX operands and decoded func3, then returns a registered 64-bit result for the EX/MEM alu_out path.
- Holds IF/ID, ID/EX and the PC through a stall output while iterating.
- Radix-2^STEP_W shift-add core; signed forms use magnitude conversion and a final negate.

Parameters:
- DATA_W, 64, operand/result width; must be a multiple of 32.
- STEP_W, 2, multiplier bits consumed per iteration; must divide 32 (1, 2, 4, 8).

Ports:
- clk  in  1  main clock
- arst  in  1  asynchronous reset, active-high
- enable  in  1  global run enable; low freezes all state
- start  in  1  ID/EX holds a multiply instruction (opcode OP/OP-32, funct7=0000001)
- flush  in  1  kill the in-flight operation (branch/jump redirect)
- func3  in  3  ID/EX func3
- is_word  in  1  OP-32 instruction (MULW)
- op_a  in  DATA_W  rs1 value (ID/EX)
- op_b  in  DATA_W  rs2 value (ID/EX)
- stall  out  1  freeze upstream pipeline registers
- busy  out  1  iteration in progress
- done  out  1  one-cycle result-valid pulse
- result  out  DATA_W  product, held until the next accepted operation

Behaviour:
- Reset (arst high, asynchronous) values:
  - state IDLE; counter, accumulator and result cleared to 0.
  - busy=0, done=0, stall=0.
- Legal ops (others are ignored: no accept, no stall):
  - func3=000: MUL, low DATA_W bits.
  - 001: MULH, signed x signed, high half.
  - 010: MULHSU, signed rs1 x unsigned rs2, high half.
  - 011: MULHU, unsigned x unsigned, high half.
  - is_word=1 with 000: MULW. Low 32 bits of op_a*op_b, sign-extended to DATA_W.
  - func3[2]=1 is division, not handled here.
- States: IDLE, CALC, DONE.
- IDLE:
  - accept = start & legal & !flush & enable.
  - On accept, latch operand magnitudes, the negate flag (sign_a XOR sign_b for signed forms) and the op.
  - Clear the accumulator; load the counter with N-1.
  - N = DATA_W/STEP_W, or 32/STEP_W for MULW. Go to CALC.
- CALC:
  - Each enabled cycle, add (mcand * STEP_W multiplier LSBs) shifted into the 2*DATA_W accumulator, then shift the multiplier right by STEP_W.
  - Counter decrements. At counter 0, go to DONE.
  - The final negate (two's complement of the 2*DATA_W product) and the half/sign-extend select are registered into result on the CALC->DONE edge.
- DONE: done=1 for exactly one enabled cycle, then IDLE.
- stall = (IDLE & accept) | CALC. stall is 0 in DONE, so the pipeline advances on the DONE edge and captures result.
- Latency: accept cycle + N CALC cycles, then DONE. The result is visible N+1 cycles after the accept edge. Default: 33 (MUL) or 17 (MULW).
- busy = (state==CALC).
- Boundary conditions:
  - start is sampled only in IDLE; start high in CALC/DONE is ignored. No re-accept on the DONE cycle because stall=0 there.
  - flush in any state moves to IDLE on the next edge; done is not asserted; result keeps its old value. flush wins over a simultaneous start.
  - enable=0 holds state, counter, accumulator and outputs unchanged, including done if frozen in DONE.
  - arst mid-operation aborts immediately; done never pulses.
- Arithmetic edge cases:
  - MULH with op_a=op_b=min negative: the magnitude 2^(DATA_W-1) fits unsigned; the product is exact.
  - Multiplication by 0 still takes the full N cycles. No early-out.

Decomposition:
- Shared package (mul_pkg):
  - func3 constants MUL_F3, MULH_F3, MULHSU_F3, MULHU_F3.
  - State encoding IDLE/CALC/DONE (2 bits).
  - Opcode constants OP_R, OP_R32, funct7 MULDIV.
- One natural sub-module, mul_step: a combinational partial-product step, (acc, mcand, mplier_bits) -> acc_next, parameterised by DATA_W and STEP_W.
- FSM, counter and sign handling stay in iter_mul_unit.

Test Plan:
- MUL 7 x -3 (op_b=0xFFFF_FFFF_FFFF_FFFD) -> stall high 33 cycles, done one cycle later, result=0xFFFF_FFFF_FFFF_FFEB.
- MULHU 0xFFFF_FFFF_FFFF_FFFF x same -> result=0xFFFF_FFFF_FFFF_FFFE. MULH with same inputs -> result=0x0.
- MULHSU op_a=-1, op_b=2 -> result=0xFFFF_FFFF_FFFF_FFFF. MULH op_a=op_b=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000.
- MULW 0x7FFF_FFFF x 2 (is_word=1) -> done after 17 cycles, result=0xFFFF_FFFF_FFFF_FFFE.
- flush at CALC cycle 10 -> IDLE next edge, stall=0, done never pulses. arst at cycle 5 of a new op -> all outputs 0 asynchronously.
- enable dropped for 4 cycles mid-CALC -> completion delayed exactly 4 cycles, same result. func3=100 with start -> stall stays 0.
